io_responder: RTL and testbench

Device-side end of the CPU's memory/IO path. It consumes the IO strobes, device-select qualifiers, low address byte and 32-bit store data produced by the CPU's memory/IO address mux. It owns the LED output register, the switch input synchronizer and debouncer, and the 8-digit seven-segment scanner. It returns the 16-bit IO read data that the mux zero-extends into the register file.

---
 rtl/io_responder.sv | 170 +++++++++++++++++
 tb/tb_io_responder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// io_responder
//
// Device-side end of the CPU memory/IO path. It holds the LED register and
// the eight-digit display register. It synchronises and debounces the board
// switches, and it scans the seven-segment display. It also returns 16-bit
// load data to the CPU combinationally.
//
// Address map (low address byte):
//   0x60  LED register      R/W, 16 bit
//   0x70  switches          RO,  16 bit (debounced)
//   0x80  display register  W,   32 bit, 8 hex digits, digit 0 = bits 3:0
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           asynchronous active-high reset
//   io_write_i      IO store strobe
//   io_read_i       IO load strobe
//   led_ctrl_i      LED device qualifier
//   switch_ctrl_i   switch device qualifier
//   digital_ctrl_i  seven-segment device qualifier
//   addr_i          low byte of the IO address
//   write_data_i    store data
//   switch_in_i     raw asynchronous board switches
//   io_read_data_o  load data back to the CPU (combinational)
//   led_out_o       LED drive, active-high
//   seg_an_o        digit anodes, active-low one-hot
//   seg_out_o       segments {dp,g,f,e,d,c,b,a}, active-low

module io_responder #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        io_write_i,
  input  logic        io_read_i,
  input  logic        led_ctrl_i,
  input  logic        switch_ctrl_i,
  input  logic        digital_ctrl_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] write_data_i,
  input  logic [15:0] switch_in_i,
  output logic [15:0] io_read_data_o,
  output logic [15:0] led_out_o,
  output logic [7:0]  seg_an_o,
  output logic [7:0]  seg_out_o
);

  localparam logic [7:0] ADDR_LED  = 8'h60;
  localparam logic [7:0] ADDR_SW   = 8'h70;
  localparam logic [7:0] ADDR_DISP = 8'h80;

  // +1 keeps the width non-zero when a parameter is 1.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [15:0]       led_q, led_d;
  logic [31:0]       disp_q, disp_d;
  logic [15:0]       sync1_q, sync2_q;
  logic [15:0]       sw_prev_q;
  logic [15:0]       sw_stable_q, sw_stable_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [3:0]        cur_digit;

  // Device register writes. Only the address selects the target. The
  // qualifiers gate access, because upstream raises several of them together.
  always_comb begin
    led_d  = led_q;
    disp_d = disp_q;
    if (io_write_i && led_ctrl_i && (addr_i == ADDR_LED)) begin
      led_d = write_data_i[15:0];
    end
    if (io_write_i && digital_ctrl_i && (addr_i == ADDR_DISP)) begin
      disp_d = write_data_i;
    end
  end

  // Debounce: any movement of the synchronised value, or agreement with the
  // accepted value, restarts the count. The new value is accepted only after
  // it has disagreed with sw_stable and held still long enough.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    sw_stable_d = sw_stable_q;
    if ((sync2_q == sw_stable_q) || (sync2_q != sw_prev_q)) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      sw_stable_d = sync2_q;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Scanner: the 3-bit digit index wraps naturally from 7 to 0.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q       <= '0;
      disp_q      <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      sw_prev_q   <= '0;
      sw_stable_q <= '0;
      db_cnt_q    <= '0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
    end else begin
      led_q       <= led_d;
      disp_q      <= disp_d;
      sync1_q     <= switch_in_i;
      sync2_q     <= sync1_q;
      sw_prev_q   <= sync2_q;
      sw_stable_q <= sw_stable_d;
      db_cnt_q    <= db_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
    end
  end

  // Load data comes straight from registered state, so a read sees the value
  // from before any write in the same cycle.
  always_comb begin
    io_read_data_o = 16'h0000;
    if (io_read_i && switch_ctrl_i && (addr_i == ADDR_SW)) begin
      io_read_data_o = sw_stable_q;
    end else if (io_read_i && led_ctrl_i && (addr_i == ADDR_LED)) begin
      io_read_data_o = led_q;
    end
  end

  assign led_out_o = led_q;
  assign seg_an_o  = ~(8'd1 << idx_q);
  assign cur_digit = disp_q[4*idx_q +: 4];

  always_comb begin
    unique case (cur_digit)
      4'h0: seg_out_o = 8'hC0;
      4'h1: seg_out_o = 8'hF9;
      4'h2: seg_out_o = 8'hA4;
      4'h3: seg_out_o = 8'hB0;
      4'h4: seg_out_o = 8'h99;
      4'h5: seg_out_o = 8'h92;
      4'h6: seg_out_o = 8'h82;
      4'h7: seg_out_o = 8'hF8;
      4'h8: seg_out_o = 8'h80;
      4'h9: seg_out_o = 8'h90;
      4'hA: seg_out_o = 8'h88;
      4'hB: seg_out_o = 8'h83;
      4'hC: seg_out_o = 8'hC6;
      4'hD: seg_out_o = 8'hA1;
      4'hE: seg_out_o = 8'h86;
      4'hF: seg_out_o = 8'h8E;
      default: seg_out_o = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder
//
// Directed bench for io_responder, built with SCAN_DIV=2 and DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge. Outputs are sampled just before the
// inputs change.

module tb_io_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        io_write_i, io_read_i;
  logic        led_ctrl_i, switch_ctrl_i, digital_ctrl_i;
  logic [7:0]  addr_i;
  logic [31:0] write_data_i;
  logic [15:0] switch_in_i;
  logic [15:0] io_read_data_o, led_out_o;
  logic [7:0]  seg_an_o, seg_out_o;

  int evalCount = 0;
  int failCount = 0;

  // Segment codes for 32'h1234_ABCD, listed by digit index 0..7.
  localparam logic [7:0] SCAN_SEG [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88,
                                          8'h99, 8'hB0, 8'hA4, 8'hF9};

  io_responder #(.SCAN_DIV(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .io_write_i     (io_write_i),
    .io_read_i      (io_read_i),
    .led_ctrl_i     (led_ctrl_i),
    .switch_ctrl_i  (switch_ctrl_i),
    .digital_ctrl_i (digital_ctrl_i),
    .addr_i         (addr_i),
    .write_data_i   (write_data_i),
    .switch_in_i    (switch_in_i),
    .io_read_data_o (io_read_data_o),
    .led_out_o      (led_out_o),
    .seg_an_o       (seg_an_o),
    .seg_out_o      (seg_out_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic ledC,
                               input logic swC, input logic digC,
                               input logic [7:0] a, input logic [31:0] d);
    io_write_i     = wr;
    io_read_i      = rd;
    led_ctrl_i     = ledC;
    switch_ctrl_i  = swC;
    digital_ctrl_i = digC;
    addr_i         = a;
    write_data_i   = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    evalCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic        found;
    logic        glitchSeen;
    int          latency;
    int          idx;
    logic [7:0]  one;

    one = 8'd1;
    rst_i       = 1'b1;
    switch_in_i = 16'h0000;
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 32'h0);
    tick();

    checkOutput("reset_led_out", led_out_o, 32'h0);
    checkOutput("reset_seg_an", seg_an_o, 32'hFE);
    checkOutput("reset_seg_out", seg_out_o, 32'hC0);
    checkOutput("reset_read_data", io_read_data_o, 32'h0);
    rst_i = 1'b0;

    // LED write, then a read at 0x60.
    applyStimulus(1, 0, 1, 0, 1, 8'h60, 32'hDEAD_BEEF);
    tick();
    checkOutput("led_write", led_out_o, 32'hBEEF);
    applyStimulus(0, 1, 1, 0, 1, 8'h60, 32'h0);
    #1;
    checkOutput("led_readback", io_read_data_o, 32'hBEEF);

    applyStimulus(0, 1, 0, 0, 0, 8'h60, 32'h0);
    #1;
    checkOutput("led_read_unqualified", io_read_data_o, 32'h0);

    applyStimulus(1, 0, 0, 0, 0, 8'h60, 32'h1111_2222);
    tick();
    checkOutput("led_write_no_ctrl", led_out_o, 32'hBEEF);
    applyStimulus(1, 0, 1, 0, 1, 8'h64, 32'h3333_4444);
    tick();
    checkOutput("led_write_addr64", led_out_o, 32'hBEEF);

    // A simultaneous read and write returns the old value. The new value is visible next cycle.
    applyStimulus(1, 1, 1, 0, 1, 8'h60, 32'h0000_1357);
    #1;
    checkOutput("rw_same_cycle_old", io_read_data_o, 32'hBEEF);
    tick();
    applyStimulus(0, 1, 1, 0, 1, 8'h60, 32'h0);
    #1;
    checkOutput("rw_led_out_new", led_out_o, 32'h1357);
    checkOutput("rw_read_new", io_read_data_o, 32'h1357);

    applyStimulus(0, 1, 1, 1, 1, 8'h90, 32'h0);
    #1;
    checkOutput("read_unmapped_90", io_read_data_o, 32'h0);

    // Debounce: a clean change must be accepted within 6 +/- 1 cycles.
    applyStimulus(0, 1, 0, 1, 0, 8'h70, 32'h0);
    switch_in_i = 16'h00A5;
    found   = 1'b0;
    latency = 0;
    for (int i = 1; i <= 12 && !found; i++) begin
      tick();
      if (io_read_data_o == 16'h00A5) begin
        found   = 1'b1;
        latency = i;
      end
    end
    checkOutput("debounce_accepted", found, 1);
    checkOutput("debounce_latency_5_to_7", (latency >= 5 && latency <= 7), 1);

    // A two-cycle glitch must never be accepted.
    switch_in_i = 16'hFFFF;
    tick();
    tick();
    switch_in_i = 16'h00A5;
    glitchSeen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (io_read_data_o !== 16'h00A5) glitchSeen = 1'b1;
    end
    checkOutput("glitch_rejected", glitchSeen, 0);

    // Writes to the switch address change nothing.
    applyStimulus(1, 0, 1, 1, 1, 8'h70, 32'h0000_FFFF);
    tick();
    applyStimulus(0, 1, 1, 1, 1, 8'h70, 32'h0);
    #1;
    checkOutput("write70_sw_unchanged", io_read_data_o, 32'h00A5);
    checkOutput("write70_led_unchanged", led_out_o, 32'h1357);

    // Asynchronous reset mid-scan with the LEDs fully on.
    applyStimulus(1, 0, 1, 0, 1, 8'h60, 32'h0000_FFFF);
    tick();
    applyStimulus(1, 1, 1, 0, 1, 8'h80, 32'h8888_8888);
    for (int i = 0; i < 6 && seg_an_o == 8'hFE; i++) tick();
    applyStimulus(0, 1, 1, 0, 1, 8'h60, 32'h0);
    #1;
    checkOutput("pre_reset_led_full", led_out_o, 32'hFFFF);
    rst_i = 1'b1;
    #1;
    checkOutput("async_reset_led_out", led_out_o, 32'h0);
    checkOutput("async_reset_seg_an", seg_an_o, 32'hFE);
    checkOutput("async_reset_seg_out", seg_out_o, 32'hC0);
    checkOutput("async_reset_read", io_read_data_o, 32'h0);
    tick();
    rst_i = 1'b0;

    // Scanner from idx 0 and scan_cnt 0. There are two cycles per digit and 16 cycles per refresh.
    applyStimulus(1, 0, 1, 0, 1, 8'h80, 32'h1234_ABCD);
    #1;
    checkOutput("scan_pre_write_seg", seg_out_o, 32'hC0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) applyStimulus(0, 0, 0, 0, 0, 8'h00, 32'h0);
      idx = (k / 2) % 8;
      checkOutput($sformatf("scan_an_k%0d", k), seg_an_o, {24'h0, ~(one << idx)});
      checkOutput($sformatf("scan_seg_k%0d", k), seg_out_o, {24'h0, SCAN_SEG[idx]});
    end

    // A write while scan_cnt is 1. It lands on the same edge that advances to digit 1.
    tick();
    checkOutput("mid_an_idx0", seg_an_o, 32'hFE);
    checkOutput("mid_seg_idx0", seg_out_o, 32'hA1);
    applyStimulus(1, 0, 1, 0, 1, 8'h80, 32'h1234_AB5D);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 8'h00, 32'h0);
    checkOutput("mid_an_idx1", seg_an_o, 32'hFD);
    checkOutput("mid_seg_new_digit", seg_out_o, 32'h92);
    tick();
    checkOutput("mid_an_idx1_hold", seg_an_o, 32'hFD);
    checkOutput("mid_seg_hold", seg_out_o, 32'h92);
    tick();
    checkOutput("mid_an_idx2", seg_an_o, 32'hFB);
    checkOutput("mid_seg_idx2", seg_out_o, 32'h83);

    $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
    $finish;
  end

endmodule
